// File: rtl/spi_cmd_seq.sv
// UART-command to SPI-transaction sequencer: one command byte (plus a data byte
// for writes) becomes a single SPI access, answered with exactly one response byte.
module spi_cmd_seq #(
  parameter int unsigned TIMEOUT  = 65535,
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       spi_en,
  output logic       spi_rw,
  output logic [6:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic [7:0] spi_rdata,
  input  logic       spi_done,
  output logic       busy,
  output logic       err,
  output logic       drop
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             spi_en_q, spi_en_d;
  logic             spi_rw_q, spi_rw_d;
  logic [6:0]       spi_addr_q, spi_addr_d;
  logic [7:0]       spi_wdata_q, spi_wdata_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;

  logic [CNT_W:0]   cnt_inc_c;
  logic             tmo_c;
  logic             rise_c;

  // Timeout fires on the cycle whose increment would make the counter equal TIMEOUT.
  assign cnt_inc_c = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign tmo_c     = (cnt_inc_c == (CNT_W+1)'(TIMEOUT));
  // Only a fresh 0->1 of spi_done counts; a level held from before WAIT is stale.
  assign rise_c    = spi_done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      spi_en_q    <= 1'b0;
      spi_rw_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= spi_done;
      spi_en_q    <= spi_en_d;
      spi_rw_q    <= spi_rw_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    spi_rw_d    = spi_rw_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    drop_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          spi_rw_d   = rx_data[7];
          spi_addr_d = rx_data[6:0];
          state_d    = rx_data[7] ? S_ISSUE : S_GET;
        end
      end
      S_GET: begin
        // A data byte arriving on the timeout cycle still wins.
        if (rx_valid) begin
          spi_wdata_d = rx_data;
          state_d     = S_ISSUE;
        end else if (tmo_c) begin
          err_d     = 1'b1;
          tx_data_d = ERR_BYTE;
          state_d   = S_RESP;
        end
      end
      S_ISSUE: begin
        drop_d  = rx_valid;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        drop_d = rx_valid;
        if (rise_c) begin
          tx_data_d = spi_rw_q ? spi_rdata : ACK_BYTE;
          state_d   = S_RESP;
        end else if (tmo_c) begin
          err_d     = 1'b1;
          tx_data_d = ERR_BYTE;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        drop_d = rx_valid;
        if (tx_valid_q && tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts from zero on every state entry.
    if ((state_d == state_q) && ((state_q == S_GET) || (state_q == S_WAIT))) begin
      cnt_d = cnt_inc_c[CNT_W-1:0];
    end else begin
      cnt_d = '0;
    end

    spi_en_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
    tx_valid_d = (state_d == S_RESP);
    busy_d     = (state_d != S_IDLE);
  end

  assign spi_en    = spi_en_q;
  assign spi_rw    = spi_rw_q;
  assign spi_addr  = spi_addr_q;
  assign spi_wdata = spi_wdata_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: a sequential transaction-level model predicts every
// output each cycle; directed scenarios add literal checks on key values.
module tb_spi_cmd_seq;

  localparam int unsigned TMO = 20;
  localparam logic [7:0]  ACK = 8'hA5;
  localparam logic [7:0]  ERB = 8'hEE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       spi_en, spi_rw;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata = '0;
  logic       spi_done = 1'b0;
  logic       busy, err, drop;

  spi_cmd_seq #(.TIMEOUT(TMO), .ACK_BYTE(ACK), .ERR_BYTE(ERB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .spi_en(spi_en), .spi_rw(spi_rw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done), .busy(busy), .err(err), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_drop = 0;
  int n_hs = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic       e_en, e_rw, e_valid, e_busy, e_err, e_drop;
  logic [6:0] e_addr;
  logic [7:0] e_wdata, e_tx;
  bit         ab, m_discard;

  task automatic reset_exp();
    e_en = 0; e_rw = 0; e_valid = 0; e_busy = 0; e_err = 0; e_drop = 0;
    e_addr = '0; e_wdata = '0; e_tx = '0; m_discard = 0;
  endtask

  // One clock: pulses last a cycle; a byte is discarded while busy with a transaction.
  task automatic tick();
    @(posedge clk);
    e_err  = 0;
    e_drop = m_discard && rx_valid;
    if (!rst_n) begin
      ab = 1;
      reset_exp();
    end
  endtask

  initial begin : model
    logic [7:0] cmd;
    int         n;
    logic       prev;
    bit         ok;
    reset_exp();
    ab = 0;
    forever begin
      ab = 0;
      e_busy = 0; e_en = 0; e_valid = 0; m_discard = 0;
      do tick(); while (!ab && !rx_valid);
      if (ab) continue;
      cmd = rx_data;
      e_rw = cmd[7]; e_addr = cmd[6:0]; e_busy = 1;
      ok = 1;
      if (!cmd[7]) begin
        n = 0; ok = 0;
        forever begin
          tick();
          if (ab) break;
          if (rx_valid) begin e_wdata = rx_data; ok = 1; break; end
          n++;
          if (n == TMO) break;
        end
        if (ab) continue;
      end
      if (ok) begin
        e_en = 1; m_discard = 1;
        tick();
        if (ab) continue;
        prev = spi_done; n = 0; ok = 0;
        forever begin
          tick();
          if (ab) break;
          if (spi_done && !prev) begin ok = 1; break; end
          prev = spi_done;
          n++;
          if (n == TMO) break;
        end
        if (ab) continue;
      end
      if (ok) e_tx = cmd[7] ? spi_rdata : ACK;
      else begin e_err = 1; e_tx = ERB; end
      e_en = 0; e_valid = 1; m_discard = 1;
      do tick(); while (!ab && !tx_ready);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("spi_en",    8'(spi_en),    rst_n ? 8'(e_en)    : 8'h0);
      chk("spi_rw",    8'(spi_rw),    rst_n ? 8'(e_rw)    : 8'h0);
      chk("spi_addr",  8'(spi_addr),  rst_n ? 8'(e_addr)  : 8'h0);
      chk("spi_wdata", spi_wdata,     rst_n ? e_wdata     : 8'h0);
      chk("tx_valid",  8'(tx_valid),  rst_n ? 8'(e_valid) : 8'h0);
      chk("tx_data",   tx_data,       rst_n ? e_tx        : 8'h0);
      chk("busy",      8'(busy),      rst_n ? 8'(e_busy)  : 8'h0);
      chk("err",       8'(err),       rst_n ? 8'(e_err)   : 8'h0);
      chk("drop",      8'(drop),      rst_n ? 8'(e_drop)  : 8'h0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (drop) n_drop++;
      if (tx_valid && tx_ready) n_hs++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    cyc(1);
    rx_valid = 0;
  endtask

  task automatic pulse_done();
    spi_done = 1;
    cyc(1);
    spi_done = 0;
  endtask

  // Returns at the negedge where the condition holds (0: spi_en, 1: tx_valid, 2: idle).
  task automatic wait_sig(input int sel, input string nm);
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = spi_en;
        1:       hit = tx_valid;
        default: hit = !busy;
      endcase
    end
    chk(nm, 8'(hit), 8'h1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, h0, n;
    cyc(2);
    chk_on = 1;
    @(negedge clk);
    chk("rst_tx_valid", 8'(tx_valid), 8'h0);
    chk("rst_busy",     8'(busy),     8'h0);
    chk("rst_tx_data",  tx_data,      8'h0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(1);

    // Write 0x12 <- 0x3C
    h0 = n_hs;
    send_byte(8'h12);
    send_byte(8'h3C);
    wait_sig(0, "wr_en");
    chk("wr_rw", 8'(spi_rw), 8'h0);
    chk("wr_addr", 8'(spi_addr), 8'h12);
    chk("wr_wdata", spi_wdata, 8'h3C);
    cyc(2);
    pulse_done();
    wait_sig(1, "wr_txv");
    chk("wr_tx", tx_data, 8'hA5);
    cyc(1);
    wait_sig(2, "wr_idle");
    cyc(2);
    chk("wr_hs_once", 8'(n_hs - h0), 8'h1);

    // Read 0x05 -> 0x77
    spi_rdata = 8'h77;
    send_byte(8'h85);
    wait_sig(0, "rd_en");
    chk("rd_rw", 8'(spi_rw), 8'h1);
    chk("rd_addr", 8'(spi_addr), 8'h05);
    cyc(2);
    pulse_done();
    wait_sig(1, "rd_txv");
    chk("rd_tx", tx_data, 8'h77);
    cyc(1);
    wait_sig(2, "rd_idle");
    cyc(1);

    // Stale done level, plus a byte discarded mid-wait
    spi_rdata = 8'hC3;
    spi_done = 1;
    d0 = n_drop;
    send_byte(8'h85);
    cyc(5);
    send_byte(8'h99);
    @(negedge clk);
    chk("stale_no_cmpl", 8'(tx_valid), 8'h0);
    @(posedge clk); #1;
    spi_done = 0;
    cyc(2);
    pulse_done();
    wait_sig(1, "stale_txv");
    chk("stale_tx", tx_data, 8'hC3);
    chk("stale_drop", 8'(n_drop - d0), 8'h1);
    cyc(1);
    wait_sig(2, "stale_idle");
    cyc(1);

    // Timeout in WAIT_DONE: err lands TMO+1 negedges after the ISSUE negedge
    send_byte(8'h81);
    wait_sig(0, "tw_en");
    n = 0;
    for (int i = 0; i < 60 && !err; i++) begin @(negedge clk); n++; end
    chk("tw_latency", 8'(n), 8'(TMO + 1));
    chk("tw_tx", tx_data, 8'hEE);
    chk("tw_en_low", 8'(spi_en), 8'h0);
    cyc(1);
    wait_sig(2, "tw_idle");
    cyc(1);

    // Timeout in GET_DATA
    send_byte(8'h22);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err) break;
      n++;
    end
    chk("tg_latency", 8'(n), 8'(TMO));
    chk("tg_tx", tx_data, 8'hEE);
    cyc(1);
    wait_sig(2, "tg_idle");
    cyc(1);

    // Data byte on the GET_DATA timeout cycle wins
    send_byte(8'h33);
    cyc(TMO - 1);
    send_byte(8'h44);
    @(negedge clk);
    chk("rx_win_err", 8'(err), 8'h0);
    chk("rx_win_en", 8'(spi_en), 8'h1);
    chk("rx_win_wdata", spi_wdata, 8'h44);
    cyc(2);
    pulse_done();
    wait_sig(1, "rx_win_txv");
    chk("rx_win_tx", tx_data, 8'hA5);
    cyc(1);
    wait_sig(2, "rx_win_idle");
    cyc(1);

    // Completion on the WAIT_DONE timeout cycle wins
    spi_rdata = 8'h6B;
    send_byte(8'h8F);
    cyc(1 + TMO - 1);
    pulse_done();
    @(negedge clk);
    chk("done_win_err", 8'(err), 8'h0);
    chk("done_win_txv", 8'(tx_valid), 8'h1);
    chk("done_win_tx", tx_data, 8'h6B);
    cyc(1);
    wait_sig(2, "done_win_idle");
    cyc(1);

    // Backpressure with a byte injected in RESP
    tx_ready = 0;
    spi_rdata = 8'h3E;
    d0 = n_drop; h0 = n_hs;
    send_byte(8'h8A);
    cyc(2);
    pulse_done();
    cyc(3);
    send_byte(8'h55);
    cyc(5);
    @(negedge clk);
    chk("bp_txv", 8'(tx_valid), 8'h1);
    chk("bp_tx", tx_data, 8'h3E);
    @(posedge clk); #1;
    tx_ready = 1;
    cyc(3);
    chk("bp_hs", 8'(n_hs - h0), 8'h1);
    chk("bp_drop", 8'(n_drop - d0), 8'h1);
    chk("bp_idle", 8'(busy), 8'h0);

    // Back-to-back byte on the handshake cycle is dropped
    spi_rdata = 8'h19;
    d0 = n_drop;
    send_byte(8'h84);
    cyc(2);
    pulse_done();
    send_byte(8'h01);
    cyc(3);
    chk("b2b_drop", 8'(n_drop - d0), 8'h1);
    chk("b2b_idle", 8'(busy), 8'h0);

    // Reset during WAIT_DONE, then a normal write
    h0 = n_hs;
    send_byte(8'h90);
    cyc(3);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_en", 8'(spi_en), 8'h0);
    chk("rst_mid_busy", 8'(busy), 8'h0);
    chk("rst_mid_addr", 8'(spi_addr), 8'h0);
    @(posedge clk); #1;
    cyc(1);
    rst_n = 1;
    cyc(2);
    chk("rst_no_resp", 8'(n_hs - h0), 8'h0);
    send_byte(8'h7F);
    send_byte(8'hC0);
    wait_sig(0, "post_rst_en");
    chk("post_rst_addr", 8'(spi_addr), 8'h7F);
    chk("post_rst_wdata", spi_wdata, 8'hC0);
    cyc(2);
    pulse_done();
    wait_sig(1, "post_rst_txv");
    chk("post_rst_tx", tx_data, 8'hA5);
    cyc(1);
    wait_sig(2, "post_rst_idle");
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
